// File: rtl/bus_pkg.sv
// Shared types and constants for the bus arbiter mux.
// Holds the FSM state encoding and arbitration mode codes.
package bus_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    DRIVE = 1'b1
  } state_t;

  localparam int MODE_RR    = 0;
  localparam int MODE_FIXED = 1;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational winner search over masked requests.
// Round-robin from last_winner+1, or lowest index first.
module rr_arbiter #(
  parameter int N  = 8,
  parameter int SW = 3
) (
  input  logic [N-1:0]  req,
  input  logic [N-1:0]  mask,
  input  logic [SW-1:0] last_winner,
  input  logic          mode,
  output logic [SW-1:0] winner,
  output logic          valid
);

  logic [N-1:0] eff;

  assign eff = req & ~mask;

  // First eligible requester in search order wins.
  always_comb begin
    int idx;
    winner = '0;
    valid  = 1'b0;
    idx    = 0;
    for (int i = 0; i < N; i++) begin
      if (mode)
        idx = i;
      else
        idx = (int'(last_winner) + 1 + i) % N;
      if (!valid && eff[idx]) begin
        winner = SW'(idx);
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter_mux.sv
// N-source bus arbiter with registered output word.
// Supports locked bursts bounded by MAX_BURST.
module bus_arbiter_mux
  import bus_pkg::*;
#(
  parameter int W         = 16,
  parameter int N         = 8,
  parameter int MODE      = 0,
  parameter int MAX_BURST = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N-1:0]          req,
  input  logic [N-1:0]          lock,
  input  logic [N*W-1:0]        data_in,
  input  logic                  bus_ready,
  output logic [N-1:0]          grant,
  output logic                  bus_valid,
  output logic [$clog2(N)-1:0]  bus_sel,
  output logic [W-1:0]          bus_out
);

  localparam int SW = $clog2(N);

  state_t        state, state_n;
  logic [N-1:0]  grant_n;
  logic [SW-1:0] sel_n;
  logic [W-1:0]  out_n;
  logic [7:0]    burst_cnt, cnt_n;
  logic [SW-1:0] last_winner, last_n;
  logic [SW-1:0] last_ref;
  logic [SW-1:0] win;
  logic          win_vld;
  logic [N-1:0]  mask;
  logic          own_lock;
  logic          burst_ok;
  logic          limit_hit;
  logic          others;
  logic [W-1:0]  win_data;
  logic [W-1:0]  own_data;

  assign bus_valid = (state == DRIVE);
  assign own_lock  = |(req & lock & grant);
  assign burst_ok  = ({1'b0, burst_cnt} + 9'd1) < 9'(MAX_BURST);
  assign limit_hit = own_lock && !burst_ok;
  assign others    = |(req & ~grant);
  assign mask      = (limit_hit && others) ? grant : '0;
  assign last_ref  = (state == DRIVE) ? bus_sel : last_winner;
  assign win_data  = data_in[int'(win)*W +: W];
  assign own_data  = data_in[int'(bus_sel)*W +: W];

  rr_arbiter #(
    .N  (N),
    .SW (SW)
  ) u_arb (
    .req         (req),
    .mask        (mask),
    .last_winner (last_ref),
    .mode        (MODE == MODE_FIXED),
    .winner      (win),
    .valid       (win_vld)
  );

  // Next-state and next-capture decision.
  always_comb begin
    state_n = state;
    grant_n = grant;
    sel_n   = bus_sel;
    out_n   = bus_out;
    cnt_n   = burst_cnt;
    last_n  = last_winner;
    unique case (state)
      IDLE: begin
        if (win_vld) begin
          state_n = DRIVE;
          grant_n = N'(1) << win;
          sel_n   = win;
          out_n   = win_data;
          cnt_n   = '0;
        end
      end
      DRIVE: begin
        if (bus_ready) begin
          last_n = bus_sel;
          if (own_lock && burst_ok) begin
            out_n = own_data;
            cnt_n = burst_cnt + 8'd1;
          end else if (win_vld) begin
            grant_n = N'(1) << win;
            sel_n   = win;
            out_n   = win_data;
            cnt_n   = '0;
          end else begin
            state_n = IDLE;
            grant_n = '0;
            out_n   = '0;
            cnt_n   = '0;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State, capture register, burst count and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      grant       <= '0;
      bus_sel     <= '0;
      bus_out     <= '0;
      burst_cnt   <= '0;
      last_winner <= SW'(N - 1);
    end else begin
      state       <= state_n;
      grant       <= grant_n;
      bus_sel     <= sel_n;
      bus_out     <= out_n;
      burst_cnt   <= cnt_n;
      last_winner <= last_n;
    end
  end

endmodule

// File: doc/bus_arbiter_mux.md
BUS_ARBITER_MUX -- requirements
Module: bus_arbiter_mux

Interface
REQ-001 Parameter W, default 16, data width of every source and of the bus.
REQ-002 Parameter N, default 8, number of source channels (2..16).
REQ-003 Parameter MODE, default 0, arbitration policy: 0 = round-robin, 1 = fixed priority (lowest index wins).
REQ-004 Parameter MAX_BURST, default 4, maximum consecutive locked transfers by one source (1..255).
REQ-005 clk  input  1  single clock; all state changes on rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 req  input  N  per-source request, level.
REQ-008 lock  input  N  per-source burst lock, sampled with req.
REQ-009 data_in  input  N*W  flattened source data; channel k at bits [k*W+W-1 : k*W].
REQ-010 bus_ready  input  1  consumer accepts bus_out this cycle.
REQ-011 grant  output  N  one-hot owner of the current transfer, zero when idle.
REQ-012 bus_valid  output  1  bus_out holds a captured word.
REQ-013 bus_sel  output  clog2(N)  index of the current owner.
REQ-014 bus_out  output  W  registered bus word.

Function
REQ-015 The FSM SHALL have two states: IDLE (no owner) and DRIVE (word captured, awaiting bus_ready).
REQ-016 In IDLE with req nonzero, the block SHALL select a winner and, on the next edge, enter DRIVE with grant = onehot(winner), bus_sel = winner, bus_out = data_in[winner] sampled that cycle, and bus_valid = 1 (latency: one cycle from req to bus_valid).
REQ-017 MODE 0 SHALL pick the first requester searching upward from last_winner+1, wrapping from N-1 to 0.
REQ-018 MODE 1 SHALL pick the lowest-index requester; last_winner is still updated but unused.
REQ-019 In DRIVE with bus_ready = 0, grant, bus_sel, bus_out and bus_valid SHALL hold unchanged, regardless of req, lock or data_in changes.
REQ-020 A transfer completes on the edge where bus_valid = 1 and bus_ready = 1; last_winner SHALL then take bus_sel.
REQ-021 On completion, if req[owner] and lock[owner] are both 1 and burst_cnt+1 < MAX_BURST, the block SHALL recapture data_in[owner], stay in DRIVE, and increment burst_cnt.
REQ-022 On completion otherwise, if any req is set, the block SHALL arbitrate in the same cycle and recapture back-to-back with no idle cycle, and clear burst_cnt.
REQ-023 When the MAX_BURST limit is reached and another source requests, the owner SHALL be excluded from that one arbitration; if no other source requests, the owner MAY win again and burst_cnt SHALL clear.
REQ-024 On completion with req all zero, the block SHALL enter IDLE with bus_valid = 0, grant = 0, bus_out = 0, and bus_sel unchanged.
REQ-025 bus_out SHALL read all-zero whenever bus_valid = 0.
REQ-026 Deassertion of req[owner] during DRIVE SHALL NOT cancel the captured word.

Reset
REQ-027 While rst_n = 0: state = IDLE, grant = 0, bus_valid = 0, bus_sel = 0, bus_out = 0, burst_cnt = 0, last_winner = N-1; effective immediately, no clock required.
REQ-028 A reset asserted mid-DRIVE SHALL discard the captured word; the first arbitration after release SHALL start the round-robin search at channel 0.

Structure
REQ-029 The state enum and the MODE_RR/MODE_FIXED constants SHALL live in shared package bus_pkg.
REQ-030 The winner search SHALL be a combinational sub-module rr_arbiter (inputs req, mask, last_winner, mode; outputs winner index and valid).
REQ-031 The top level SHALL contain only the FSM, the capture register, burst_cnt and last_winner.

Verification (N=8, W=16, MAX_BURST=4)
REQ-032 Reset, then req=8'h01, data_in[0]=16'hA5A5 -> one cycle later bus_valid=1, grant=8'h01, bus_out=16'hA5A5.
REQ-033 MODE 0, req=8'h8C held, bus_ready=1 -> owners 2,3,7,2,3,7..., back-to-back with bus_valid never dropping.
REQ-034 MODE 1, req=8'h8C -> owner 2 every transfer; then req=8'h80 -> owner 7.
REQ-035 req=8'h03, lock[0]=1, bus_ready=1 -> four transfers from ch0, then one from ch1, then ch0 again.
REQ-036 In DRIVE with bus_ready=0 for 5 cycles while data_in[owner] and req toggle -> bus_out and grant constant; after one cycle of bus_ready=1 with req=0 -> IDLE, bus_out=0.
REQ-037 rst_n pulsed low mid-DRIVE, asynchronous to clk -> outputs zero immediately; after release req=8'hFF -> first owner is channel 0.
